// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch FSM states and PC control encodings.
// Provides:
//   ADDR_WIDTH, INSTR_WIDTH - instruction address / instruction word widths
//   fetch_state_t           - fetch FSM state (IDLE=0, BUSY=1, DROP=2)
//   pc_op_t                 - PC control select, shared with the program counter
package cpu_pkg;
    localparam int ADDR_WIDTH  = 16;
    localparam int INSTR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        INCREMENT = 2'd1,
        REL_JUMP  = 2'd2,
        ABS_JUMP  = 2'd3
    } pc_op_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO with flush, feeding fetched instructions to decode.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   flush_i          - empty the queue; wins over push_i and pop_i
//   push_i, data_i   - write data_i at the tail
//   pop_i            - drop the head entry
//   head_o           - head entry, or the last head shown once the queue empties
//   valid_o          - queue non-empty
//   count_o          - number of stored entries
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_q + PW'(pop_i);
            wr_q    <= wr_q + PW'(push_i);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= data_i;
    end

    // Remembers the visible head so the output holds steady after the queue drains.
    always_ff @(posedge clk) begin
        if (reset) last_q <= '0;
        else if (count_q != '0) last_q <= mem_q[rd_q];
    end

    assign valid_o = count_q != '0;
    assign head_o  = valid_o ? mem_q[rd_q] : last_q;
    assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: issues req/ack instruction reads and queues results for decode.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   pc_addr                    - current PC value
//   pc_hold                    - 1 = PC must hold; 0 only in the cycle an instruction is pushed
//   flush                      - taken branch/jump: drop queued and in-flight instructions
//   imem_req, imem_addr        - registered read request and address
//   imem_ack, imem_rdata       - read data valid strobe and data
//   ir, ir_pc, ir_valid        - queue head instruction, its fetch address, non-empty flag
//   ir_ready                   - decode consumes the head this cycle
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    output logic                   pc_hold,
    input  logic                   flush,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] ir,
    output logic [ADDR_WIDTH-1:0]  ir_pc,
    output logic                   ir_valid,
    input  logic                   ir_ready
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int EW = INSTR_WIDTH + ADDR_WIDTH;

    fetch_state_t          state_q;
    logic                  req_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         count;
    logic [EW-1:0]         head;
    logic                  push, pop, space;

    assign pop     = ir_valid & ir_ready;
    assign push    = (state_q == BUSY) & imem_ack & ~flush;
    // A slot freed by this cycle's pop counts, so a full queue being drained can still issue.
    assign space   = (count - CW'(pop)) < CW'(QUEUE_DEPTH);
    assign pc_hold = ~push;

    // DROP keeps the request alive until the memory answers, then throws the data away.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (!flush && space) begin
                    state_q <= BUSY;
                    req_q   <= 1'b1;
                    addr_q  <= pc_addr;
                end
                BUSY: if (imem_ack) begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end else if (flush) begin
                    state_q <= DROP;
                end
                DROP: if (imem_ack) begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({imem_rdata, addr_q}),
        .head_o  (head),
        .valid_o (ir_valid),
        .count_o (count)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir        = head[EW-1:ADDR_WIDTH];
    assign ir_pc     = head[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plus randomized check of instruction_fetch against a transaction-level model.
module tb_instruction_fetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc_addr = 16'h0;
    logic        pc_hold;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;

    instruction_fetch #(.QUEUE_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .pc_hold    (pc_hold),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [15:0] a;
    } ent_t;

    // Model: one outstanding-read record plus a queue of delivered instructions.
    ent_t        q[$];
    ent_t        m_last = '{16'h0, 16'h0};
    logic        m_active = 1'b0;
    logic        m_killed = 1'b0;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] pc_n = 16'h0;
    logic [15:0] tgt = 16'h0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic rdy, input logic ak, input logic rst);
        logic mpush;
        @(negedge clk);
        pc_addr    = pc_n;
        reset      = rst;
        flush      = fl;
        ir_ready   = rdy;
        imem_ack   = ak;
        imem_rdata = memf(m_addr);
        #1;
        mpush = m_active && !m_killed && ak && !fl;
        chk("imem_req", {15'h0, imem_req}, {15'h0, m_active});
        chk("imem_addr", imem_addr, m_addr);
        chk("pc_hold", {15'h0, pc_hold}, {15'h0, !mpush});
        chk("ir_valid", {15'h0, ir_valid}, {15'h0, q.size() != 0});
        chk("ir", ir, q.size() != 0 ? q[0].d : m_last.d);
        chk("ir_pc", ir_pc, q.size() != 0 ? q[0].a : m_last.a);
    endtask

    task automatic tick();
        logic pop, push, issue;
        if (reset) begin
            m_active = 1'b0;
            m_killed = 1'b0;
            m_addr   = 16'h0;
            q.delete();
            m_last   = '{16'h0, 16'h0};
        end else begin
            pop   = q.size() != 0 && ir_ready;
            push  = m_active && !m_killed && imem_ack && !flush;
            issue = !m_active && !flush && (q.size() - int'(pop)) < DEPTH;
            if (q.size() != 0) m_last = q[0];
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{memf(m_addr), m_addr});
            end
            if (issue) begin
                m_active = 1'b1;
                m_killed = 1'b0;
                m_addr   = pc_addr;
            end else if (m_active && imem_ack) m_active = 1'b0;
            else if (m_active && flush) m_killed = 1'b1;
            if (flush) pc_n = tgt;
            else if (!pc_hold) pc_n = pc_addr + 16'd1;
        end
        @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        // Reset state and first fetch from 0x0000
        pc_n = 16'h0000;
        drive(0, 0, 0, 1);
        chk("rst_req", {15'h0, imem_req}, 16'h0);
        chk("rst_addr", imem_addr, 16'h0);
        chk("rst_valid", {15'h0, ir_valid}, 16'h0);
        chk("rst_ir", ir, 16'h0);
        chk("rst_ir_pc", ir_pc, 16'h0);
        tick();
        drive(0, 0, 0, 0); tick();
        drive(0, 0, 1, 0);
        chk("t1_req", {15'h0, imem_req}, 16'h1);
        chk("t1_addr", imem_addr, 16'h0000);
        chk("t1_hold_ack", {15'h0, pc_hold}, 16'h0);
        tick();
        drive(0, 0, 0, 0);
        chk("t1_valid", {15'h0, ir_valid}, 16'h1);
        chk("t1_ir", ir, 16'hC3A5);
        chk("t1_ir_pc", ir_pc, 16'h0000);
        chk("t1_hold", {15'h0, pc_hold}, 16'h1);
        tick();
        // Fill the queue from 0x0010 with decode stalled, then release one slot
        pc_n = 16'h0010;
        drive(0, 0, 0, 1); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, m_active, 0); tick();
        end
        drive(0, 1, 0, 0);
        chk("t2_req_full", {15'h0, imem_req}, 16'h0);
        chk("t2_hold_full", {15'h0, pc_hold}, 16'h1);
        chk("t2_head_pc", ir_pc, 16'h0010);
        chk("t2_head_ir", ir, 16'hD3A5);
        tick();
        drive(0, 0, 0, 0);
        chk("t2_req_next", {15'h0, imem_req}, 16'h1);
        chk("t2_addr_next", imem_addr, 16'h0012);
        chk("t2_head_pc2", ir_pc, 16'h0011);
        tick();
        // Slow memory: request held stable for three cycles
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0);
            chk("t3_req", {15'h0, imem_req}, 16'h1);
            chk("t3_addr", imem_addr, 16'h0012);
            chk("t3_hold", {15'h0, pc_hold}, 16'h1);
            tick();
        end
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 0, 0);
        chk("t3_head_pc", ir_pc, 16'h0011);
        tick();
        // Flush while waiting: in-flight read dropped, refetch from target
        pc_n = 16'h0030;
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 0); tick();
        tgt = 16'h0040;
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 0, 0);
        chk("t4_req_drop", {15'h0, imem_req}, 16'h1);
        chk("t4_addr_drop", imem_addr, 16'h0030);
        tick();
        drive(0, 0, 1, 0);
        chk("t4_hold_drop", {15'h0, pc_hold}, 16'h1);
        tick();
        drive(0, 0, 0, 0);
        chk("t4_valid", {15'h0, ir_valid}, 16'h0);
        chk("t4_req_idle", {15'h0, imem_req}, 16'h0);
        tick();
        drive(0, 0, 0, 0);
        chk("t4_addr_new", imem_addr, 16'h0040);
        tick();
        // Flush coinciding with ack and pop, one entry queued
        pc_n = 16'h0050;
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 0, 0);
        chk("t5_head_pc", ir_pc, 16'h0050);
        tick();
        tgt = 16'h0060;
        drive(1, 1, 1, 0); tick();
        drive(0, 0, 0, 0);
        chk("t5_valid", {15'h0, ir_valid}, 16'h0);
        chk("t5_req", {15'h0, imem_req}, 16'h0);
        tick();
        // Reset mid-transaction; late ack ignored
        pc_n = 16'h0070;
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 0); tick();
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 1, 0);
        chk("t6_req", {15'h0, imem_req}, 16'h0);
        chk("t6_hold", {15'h0, pc_hold}, 16'h1);
        tick();
        drive(0, 0, 0, 0);
        chk("t6_valid", {15'h0, ir_valid}, 16'h0);
        tick();
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic rst, fl, rdy, ak;
            rst = $urandom_range(0, 199) == 0;
            fl  = $urandom_range(0, 99) < 8;
            rdy = ((i / 200) % 3 == 0) ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 60);
            ak  = m_active ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 10);
            tgt = 16'($urandom);
            drive(fl, rdy, ak, rst);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the program counter; consumes the 16-bit instruction address and issues a req/ack read to instruction memory.
- Buffers returned instructions, each tagged with its fetch address, in a small queue for decode.
- Drives pc_hold so PC control selects PC_HOLD until the current address has been fetched.
- Discards wrong-path instructions on a taken-branch flush.

Parameters:
ADDR_WIDTH, 16, instruction address width (matches PC output)
INSTR_WIDTH, 16, instruction word width
QUEUE_DEPTH, 2, fetch queue entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pc_addr  in  ADDR_WIDTH  current PC value (instructionAddress)
pc_hold  out  1  1 = PC control must apply PC_HOLD; ignored by PC control in flush cycles
flush  in  1  taken branch/jump this cycle; PC loads new target next edge
imem_req  out  1  memory read request, registered
imem_addr  out  ADDR_WIDTH  read address, registered, stable while imem_req=1
imem_ack  in  1  read data valid this cycle (only meaningful while imem_req=1)
imem_rdata  in  INSTR_WIDTH  read data
ir  out  INSTR_WIDTH  queue head instruction
ir_pc  out  ADDR_WIDTH  fetch address of ir
ir_valid  out  1  queue non-empty
ir_ready  in  1  decode accepts head this cycle

Behaviour:
- Reset: state=IDLE, imem_req=0, imem_addr=0, queue count=0, ir_valid=0, ir=0, ir_pc=0. Reset overrides all other inputs, including mid-transaction; any ack after reset is ignored.
- pop = ir_valid & ir_ready. push = (state==BUSY) & imem_ack & !flush. space = (count - pop) < QUEUE_DEPTH.
- IDLE: if !flush & space, go to BUSY; imem_addr<=pc_addr, imem_req<=1. Otherwise stay in IDLE.
- BUSY:
  - imem_req held at 1 and imem_addr held constant until ack.
  - ack & !flush: push {imem_rdata, imem_addr}, imem_req<=0, go to IDLE.
  - ack & flush: data dropped, imem_req<=0, go to IDLE.
  - !ack & flush: go to DROP, imem_req stays 1.
- DROP: imem_req stays 1 until ack. On ack, data discarded, imem_req<=0, go to IDLE. A further flush in DROP has no extra effect.
- pc_hold = !push (combinational). The PC advances exactly once per pushed instruction. Zero-wait memory gives 1 instruction per 2 cycles.
- Queue: circular buffer with wrapping read/write pointers and a count.
  - flush clears the queue (count<=0, pointers reset) with priority over push and pop in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Push never occurs at count==QUEUE_DEPTH, guaranteed by the space check at issue.
- ir/ir_pc come combinationally from the head entry; both hold their last value when ir_valid=0.
- imem_addr is registered, so a PC change on flush never alters an outstanding request address.

Decomposition:
- Shared package (cpu_pkg): ADDR_WIDTH, INSTR_WIDTH, fetch-state encoding (IDLE=0, BUSY=1, DROP=2), PC_HOLD/INCREMENT/REL_JUMP/ABS_JUMP encodings shared with the PC.
- One sub-module: fetch_queue (parameterised synchronous FIFO with flush; push/pop/count/head outputs).

Test Plan:
- Reset, then pc_addr=0x0000, memory acks the cycle after req -> req at cycle 1; ir=mem[0], ir_pc=0x0000, ir_valid=1 after the ack edge; pc_hold=0 only in the ack cycle.
- ir_ready=0, sequential PC from 0x0010 -> two pushes (0x0010, 0x0011), then IDLE with imem_req=0 and pc_hold=1; raising ir_ready for one cycle -> exactly one new request to 0x0012.
- Ack delayed 3 cycles -> imem_req and imem_addr stable for all 3 cycles; pc_hold=1 throughout; single push.
- Flush in BUSY with no ack, ack 2 cycles later -> state DROP, data not pushed, queue empty; next request uses the new pc_addr (e.g. 0x0040).
- Flush in the same cycle as ack with 1 entry queued and ir_ready=1 -> queue empty next cycle, ir_valid=0, state IDLE.
- Reset asserted while BUSY, ack arrives the next cycle -> ack ignored, ir_valid=0, imem_req=0.
